// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state and op encodings for the cache line transfer engine
package cache_pkg;
  localparam int LINE_WIDTH = 256;
  localparam int WORD_WIDTH = 32;
  localparam int INDEX_WIDTH = 3;
  localparam int BEATS = LINE_WIDTH / WORD_WIDTH;
  localparam int CNT_WIDTH = $clog2(BEATS);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);
  localparam logic OP_REFILL = 1'b0;
  localparam logic OP_WRITEBACK = 1'b1;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    FILL = 3'd2,
    LOAD = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

// File: rtl/cache_line_xfer_line_buffer.sv
// line_buffer: one cache line register with word-indexed write, full-line load and word read mux
module line_buffer
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [CNT_WIDTH-1:0]  wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  ld_en,
  input  logic [LINE_WIDTH-1:0] ld_data,
  input  logic [CNT_WIDTH-1:0]  rd_idx,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic [LINE_WIDTH-1:0] line
);
  logic [LINE_WIDTH-1:0] line_q, line_d;
  always_comb begin
    line_d = line_q;
    if (ld_en) line_d = ld_data;
    else if (wr_en) line_d[wr_idx*WORD_WIDTH +: WORD_WIDTH] = wr_data;
  end
  always_ff @(posedge clk) line_q <= !resetn ? '0 : line_d;
  assign rd_data = line_q[rd_idx*WORD_WIDTH +: WORD_WIDTH];
  assign line = line_q;
endmodule

// File: rtl/cache_line_xfer.sv
// cache_line_xfer: refill/writeback sequencer between the line data array and 32-bit memory beats.
// Define XFER_LAST_CHECK_EN to add the sticky err output for mem_rd_last misalignment.
module cache_line_xfer
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_op,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic                   mem_rd_valid,
  output logic                   mem_rd_ready,
  input  logic [WORD_WIDTH-1:0]  mem_rd_data,
  input  logic                   mem_rd_last,
  output logic                   mem_wr_valid,
  input  logic                   mem_wr_ready,
  output logic [WORD_WIDTH-1:0]  mem_wr_data,
  output logic                   mem_wr_last,
  output logic [INDEX_WIDTH-1:0] da_waddr,
  output logic                   da_wen,
  output logic [LINE_WIDTH-1:0]  da_wdata,
  output logic [INDEX_WIDTH-1:0] da_raddr,
  input  logic [LINE_WIDTH-1:0]  da_rdata,
  output logic                   done
`ifdef XFER_LAST_CHECK_EN
  ,output logic                  err
`endif
);
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic op_q, op_d;
  logic rd_hs, wr_hs, last_beat;
  assign req_ready = state_q == IDLE;
  assign mem_rd_ready = state_q == RECV;
  assign mem_wr_valid = state_q == SEND;
  assign mem_wr_last = mem_wr_valid && last_beat;
  assign da_wen = state_q == FILL;
  assign done = state_q == DONE;
  assign da_waddr = idx_q;
  assign da_raddr = idx_q;
  assign last_beat = cnt_q == LAST_BEAT;
  assign rd_hs = mem_rd_valid && mem_rd_ready;
  assign wr_hs = mem_wr_valid && mem_wr_ready;
  line_buffer u_buf (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (rd_hs),
    .wr_idx  (cnt_q),
    .wr_data (mem_rd_data),
    .ld_en   (state_q == LOAD),
    .ld_data (da_rdata),
    .rd_idx  (cnt_q),
    .rd_data (mem_wr_data),
    .line    (da_wdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    op_d = op_q;
    case (state_q)
      IDLE: if (req_valid) begin
        idx_d = req_index;
        op_d = req_op;
        cnt_d = '0;
        state_d = req_op == OP_WRITEBACK ? LOAD : RECV;
      end
      FILL: state_d = DONE;
      LOAD: state_d = SEND;
      DONE: state_d = IDLE;
      RECV, SEND: state_d = state_q;
      default: state_d = IDLE;
    endcase
    // both directions count beats the same way; only the exit state differs
    if (rd_hs || wr_hs) begin
      cnt_d = cnt_q + 1'b1;
      if (last_beat) state_d = op_q == OP_REFILL ? FILL : DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      op_q <= OP_REFILL;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      op_q <= op_d;
    end
  end
`ifdef XFER_LAST_CHECK_EN
  logic err_q, err_d;
  always_comb err_d = err_q || (rd_hs && (mem_rd_last != last_beat));
  always_ff @(posedge clk) err_q <= resetn && err_d;
  assign err = err_q;
`else
  logic unused_rd_last;
  assign unused_rd_last = mem_rd_last;
`endif
endmodule

// File: tb/tb_cache_line_xfer.sv
// tb_cache_line_xfer: table-driven and randomized line transfers checked against a line-level array model
module tb_cache_line_xfer;
  import cache_pkg::*;
  logic clk = 1'b0, resetn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [INDEX_WIDTH-1:0] req_index = '0;
  logic mem_rd_valid = 1'b0, mem_rd_ready, mem_rd_last = 1'b0;
  logic [WORD_WIDTH-1:0] mem_rd_data = '0;
  logic mem_wr_valid, mem_wr_ready = 1'b0, mem_wr_last;
  logic [WORD_WIDTH-1:0] mem_wr_data;
  logic [INDEX_WIDTH-1:0] da_waddr, da_raddr;
  logic da_wen, done;
  logic [LINE_WIDTH-1:0] da_wdata, da_rdata;
`ifdef XFER_LAST_CHECK_EN
  logic err;
  logic bad_seen = 1'b0;
`endif
  always #5 clk = ~clk;
  cache_line_xfer dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_index(req_index),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last),
    .da_waddr(da_waddr), .da_wen(da_wen), .da_wdata(da_wdata), .da_raddr(da_raddr), .da_rdata(da_rdata),
    .done(done)
`ifdef XFER_LAST_CHECK_EN
    ,.err(err)
`endif
  );
  // data array environment plus the expected contents the model maintains
  logic [LINE_WIDTH-1:0] arr [8];
  logic [LINE_WIDTH-1:0] exp_arr [8];
  logic pl_en = 1'b0;
  logic [2:0] pl_idx = '0;
  always @(posedge clk)
    if (pl_en) arr[pl_idx] <= exp_arr[pl_idx];
    else if (da_wen) arr[da_waddr] <= da_wdata;
  assign da_rdata = arr[da_raddr];
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [LINE_WIDTH-1:0] act, input logic [LINE_WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  int cyc = 0, acc_cnt = 0, acc_cyc = 0, rd_cnt = 0, rd_cyc = 0, wen_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic [2:0] wen_addr = '0;
  logic [LINE_WIDTH-1:0] wen_data = '0;
  logic [32:0] wr_q [$];
  logic stall_prev = 1'b0;
  logic [33:0] stall_val = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (resetn) begin
      if (req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
      if (mem_rd_valid && mem_rd_ready) begin rd_cnt++; rd_cyc = cyc; end
      if (da_wen) begin wen_cnt++; wen_addr = da_waddr; wen_data = da_wdata; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (mem_wr_valid && mem_wr_ready) wr_q.push_back({mem_wr_last, mem_wr_data});
      if (stall_prev) chk("wr_stall_hold", {mem_wr_valid, mem_wr_last, mem_wr_data}, stall_val);
      stall_prev = mem_wr_valid && !mem_wr_ready;
      stall_val = {mem_wr_valid, mem_wr_last, mem_wr_data};
    end else stall_prev = 1'b0;
  typedef struct {
    logic op;
    logic [2:0] idx;
    logic [31:0] base;
    logic rnd;
    int vmode;
    int rmode;
    int abort_at;
    int bad_last;
    int exp_wen;
    int exp_lat;
  } vec_t;
  task automatic xfer(input vec_t v);
    logic [31:0] w [8];
    logic [LINE_WIDTH-1:0] line;
    logic [32:0] e;
    int snap_acc, snap_rd, snap_wen, snap_done, b, t;
    bit b2b, ok;
    for (int i = 0; i < 8; i++) begin
      w[i] = v.rnd ? $urandom : v.base + 32'(i);
      line[i*32 +: 32] = w[i];
    end
    snap_acc = acc_cnt; snap_rd = rd_cnt; snap_wen = wen_cnt; snap_done = done_cnt;
    wr_q.delete();
    b2b = done;
    req_valid = 1'b1; req_op = v.op; req_index = v.idx;
    if (b2b) chk("b2b_ready_low", req_ready, 0);
    ok = 0;
    for (t = 0; t < 20 && !ok; t++) begin
      @(posedge clk); #1;
      ok = acc_cnt != snap_acc;
    end
    req_valid = 1'b0;
    chk("req_accept", acc_cnt - snap_acc, 1);
    if (!ok) return;
    if (b2b) chk("b2b_accept_cycle", acc_cyc, done_cyc + 1);
    ok = 0;
    b = 0;
    for (t = 0; t < 300; t++) begin
      if (done) begin ok = 1; break; end
      b = rd_cnt - snap_rd;
      if (v.op == OP_REFILL && b == v.abort_at) break;
      mem_rd_valid = v.op == OP_REFILL && b < 8 && (v.vmode == 0 || $urandom_range(1) == 1);
      mem_rd_data = w[b % 8];
      mem_rd_last = v.bad_last >= 0 ? b == v.bad_last : b == 7;
      mem_wr_ready = v.rmode == 0 ? 1'b1 : v.rmode == 1 ? t % 3 == 1 : $urandom_range(1) == 1;
      @(posedge clk); #1;
    end
    mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
    if (v.abort_at >= 0) begin
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      chk("abort_req_ready", req_ready, 1);
      chk("abort_rd_ready", mem_rd_ready, 0);
      chk("abort_wen", da_wen, 0);
      chk("abort_done", done, 0);
      mem_rd_valid = 1'b1;
      repeat (12) begin @(posedge clk); #1; end
      mem_rd_valid = 1'b0;
      chk("abort_no_wen", wen_cnt - snap_wen, 0);
      chk("abort_no_done", done_cnt - snap_done, 0);
      chk("abort_line_kept", arr[v.idx], exp_arr[v.idx]);
      return;
    end
    chk("done_seen", ok, 1);
    if (!ok) return;
    @(negedge clk); #1;
    chk("done_count", done_cnt - snap_done, 1);
    chk("wen_count", wen_cnt - snap_wen, v.exp_wen);
    chk("raddr_hold", da_raddr, v.idx);
    if (v.op == OP_REFILL) begin
      chk("wen_addr", wen_addr, v.idx);
      chk("wen_line", wen_data, line);
      chk("refill_lat", done_cyc - rd_cyc, v.exp_lat);
      chk("refill_no_wr", wr_q.size(), 0);
      exp_arr[v.idx] = line;
`ifdef XFER_LAST_CHECK_EN
      if (v.bad_last >= 0) bad_seen = 1'b1;
      chk("err_flag", err, bad_seen);
`endif
    end else begin
      chk("wb_beats", wr_q.size(), 8);
      for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
        e = {i == 7, exp_arr[v.idx][i*32 +: 32]};
        chk("wb_beat", wr_q[i], e);
      end
      if (v.exp_lat > 0) chk("wb_lat", done_cyc - acc_cyc, v.exp_lat);
    end
  endtask
  vec_t tbl [9];
  vec_t rv;
  initial begin
    tbl[0] = '{1'b0, 3'd5, 32'h0, 1'b0, 0, 0, -1, -1, 1, 2};
    tbl[1] = '{1'b1, 3'd2, 32'h0, 1'b0, 0, 0, -1, -1, 0, 10};
    tbl[2] = '{1'b1, 3'd2, 32'h0, 1'b0, 0, 1, -1, -1, 0, 0};
    tbl[3] = '{1'b0, 3'd3, 32'h3300_0000, 1'b0, 1, 0, 5, -1, 0, 0};
    tbl[4] = '{1'b0, 3'd7, 32'h7700_0000, 1'b0, 0, 0, -1, -1, 1, 2};
    tbl[5] = '{1'b1, 3'd7, 32'h0, 1'b0, 0, 0, -1, -1, 0, 10};
    tbl[6] = '{1'b0, 3'd1, 32'h1100_0000, 1'b0, 1, 0, -1, 3, 1, 2};
    tbl[7] = '{1'b1, 3'd1, 32'h0, 1'b0, 0, 2, -1, -1, 0, 0};
    tbl[8] = '{1'b1, 3'd5, 32'h0, 1'b0, 0, 1, -1, -1, 0, 0};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) exp_arr[i][j*32 +: 32] = i == 2 ? 32'hA0 + 32'(j) : $urandom;
    pl_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pl_idx = 3'(i);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rd_ready", mem_rd_ready, 0);
    chk("rst_wr_valid", mem_wr_valid, 0);
    chk("rst_wr_last", mem_wr_last, 0);
    chk("rst_wen", da_wen, 0);
    chk("rst_done", done, 0);
    chk("rst_waddr", da_waddr, 0);
    chk("rst_wdata", da_wdata, 0);
    chk("rst_wr_data", mem_wr_data, 0);
`ifdef XFER_LAST_CHECK_EN
    chk("rst_err", err, 0);
`endif
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) xfer(tbl[i]);
    for (int i = 0; i < 12; i++) begin
      rv.op = 1'($urandom_range(1));
      rv.idx = 3'($urandom_range(7));
      rv.base = '0;
      rv.rnd = 1'b1;
      rv.vmode = $urandom_range(1);
      rv.rmode = $urandom_range(2);
      rv.abort_at = -1;
      rv.bad_last = -1;
      rv.exp_wen = rv.op == OP_REFILL ? 1 : 0;
      rv.exp_lat = rv.op == OP_REFILL ? 2 : rv.rmode == 0 ? 10 : 0;
      xfer(rv);
    end
    repeat (3) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
